demux_s2p: RTL and testbench

DEMUX_S2P -- requirements
Module: demux_s2p

---
 rtl/demux_s2p.sv | 118 +++++++++++
 tb/tb_demux_s2p.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/demux_s2p.sv
// Serial-to-parallel demultiplexer: collects WIDTH serial bits into one word and
// presents it with a valid/ready handshake. Overrun pulses when a finished word is dropped.
module demux_s2p #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned SelW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             inClk,
    input  logic             inRst_n,
    input  logic             inData,
    input  logic             inValid,
    input  logic             inStart,
    input  logic             inReady,
    output logic [WIDTH-1:0] outData,
    output logic             outValid,
    output logic [SelW-1:0]  outSel,
    output logic             outOverrun
);

    typedef enum logic {StIdle, StCollect} state_e;

    localparam logic [SelW-1:0] LastPos = SelW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [SelW-1:0]   pos_q, pos_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic [SelW-1:0]   pos_base;
    logic [WIDTH-1:0]  shreg_base;
    logic [WIDTH-1:0]  word;
    logic [SelW-1:0]   idx;
    logic              last_bit;
    logic              word_done;

    // State register
    always_ff @(posedge inClk) begin
        if (!inRst_n) begin
            state_q   <= StIdle;
            pos_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: collector FSM, position counter and partial-word register
    always_comb begin
        // An alignment strobe drops the partial word before the current bit is placed.
        pos_base   = inStart ? '0 : pos_q;
        shreg_base = inStart ? '0 : shreg_q;
        idx        = MSB_FIRST ? (LastPos - pos_base) : pos_base;
        word       = shreg_base;
        word[idx]  = inData;
        last_bit   = (pos_base == LastPos);
        word_done  = inValid && last_bit;

        state_d = state_q;
        pos_d   = pos_base;
        shreg_d = shreg_base;
        if (inStart) begin
            state_d = StIdle;
        end
        if (inValid) begin
            unique case (state_d)
                StIdle: begin
                    state_d = last_bit ? StIdle : StCollect;
                end
                StCollect: begin
                    if (last_bit) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
            if (last_bit) begin
                pos_d   = '0;
                shreg_d = '0;
            end else begin
                pos_d   = pos_base + 1'b1;
                shreg_d = word;
            end
        end
    end

    // Output holding register and overrun detection
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (word_done) begin
            if (!valid_q || inReady) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && inReady) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        outData    = data_q;
        outValid   = valid_q;
        outSel     = pos_q;
        outOverrun = overrun_q;
    end

endmodule

// File: tb/tb_demux_s2p.sv
// Scoreboard bench for demux_s2p: an LSB-first and an MSB-first instance share stimulus;
// expected words are queued at issue and popped by monitors on each handshake.
module tb_demux_s2p;

    logic       clk;
    logic       rst_n;
    logic       in_data;
    logic       in_valid;
    logic       in_start;
    logic       in_ready;

    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic [2:0] sel0, sel1;
    logic       ovr0, ovr1;

    int checks = 0;
    int errors = 0;
    int ovr_cnt0 = 0;
    int ovr_cnt1 = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    demux_s2p #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .inClk      (clk),
        .inRst_n    (rst_n),
        .inData     (in_data),
        .inValid    (in_valid),
        .inStart    (in_start),
        .inReady    (in_ready),
        .outData    (data0),
        .outValid   (valid0),
        .outSel     (sel0),
        .outOverrun (ovr0)
    );

    demux_s2p #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .inClk      (clk),
        .inRst_n    (rst_n),
        .inData     (in_data),
        .inValid    (in_valid),
        .inStart    (in_start),
        .inReady    (in_ready),
        .outData    (data1),
        .outValid   (valid1),
        .outSel     (sel1),
        .outOverrun (ovr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: a word is consumed whenever valid and ready meet.
    always @(negedge clk) begin
        if (rst_n && valid0 && in_ready) begin
            if (q0.size() == 0) chk("lsb_unexpected_word", {24'd0, data0}, 32'hdead);
            else chk("lsb_word", {24'd0, data0}, {24'd0, q0.pop_front()});
        end
        if (rst_n && valid1 && in_ready) begin
            if (q1.size() == 0) chk("msb_unexpected_word", {24'd0, data1}, 32'hdead);
            else chk("msb_word", {24'd0, data1}, {24'd0, q1.pop_front()});
        end
        if (ovr0) ovr_cnt0++;
        if (ovr1) ovr_cnt1++;
    end

    // Drive one cycle of inputs, then return #1 after the sampling edge.
    task automatic drive(input logic v, input logic d, input logic s);
        in_valid = v;
        in_data  = d;
        in_start = s;
        @(posedge clk);
        #1;
    endtask

    // Send a byte LSB-first in bit order (bit 0 of the argument goes first).
    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) drive(1'b1, b[i], 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data0"}, {24'd0, data0}, 32'h0);
        chk({tag, "_data1"}, {24'd0, data1}, 32'h0);
        chk({tag, "_valid"}, {30'd0, valid0, valid1}, 32'h0);
        chk({tag, "_sel"}, {26'd0, sel0, sel1}, 32'h0);
        chk({tag, "_ovr"}, {30'd0, ovr0, ovr1}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base0, base1;
        rst_n    = 1'b0;
        in_data  = 1'b1;
        in_valid = 1'b1;
        in_start = 1'b0;
        in_ready = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 1'b0);
        check_zero("reset");
        rst_n = 1'b1;

        // A5 then back-to-back 11110000 (LSB-first -> 0F, MSB-first -> F0)
        q0.push_back(8'hA5); q1.push_back(8'hA5);
        q0.push_back(8'h0F); q1.push_back(8'hF0);
        send_byte(8'hA5);
        chk("a5_valid", {30'd0, valid0, valid1}, 32'h3);
        chk("a5_sel_wrapped", {29'd0, sel0}, 32'h0);
        send_byte(8'h0F);
        chk("f0_valid", {30'd0, valid0, valid1}, 32'h3);
        drive(1'b0, 1'b0, 1'b0);
        chk("f0_valid_fall", {30'd0, valid0, valid1}, 32'h0);

        // Overrun: 3C held, C3 dropped with a single overrun pulse
        in_ready = 1'b0;
        base0 = ovr_cnt0;
        base1 = ovr_cnt1;
        q0.push_back(8'h3C); q1.push_back(8'h3C);
        send_byte(8'h3C);
        send_byte(8'hC3);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("ovr_held0", {24'd0, data0}, 32'h3C);
        chk("ovr_held1", {24'd0, data1}, 32'h3C);
        chk("ovr_pulses0", ovr_cnt0 - base0, 32'd1);
        chk("ovr_pulses1", ovr_cnt1 - base1, 32'd1);
        chk("ovr_still_valid", {30'd0, valid0, valid1}, 32'h3);
        in_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("ovr_release_fall", {30'd0, valid0, valid1}, 32'h0);

        // Alignment strobe discards 3 partial bits; word 81
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
        chk("pre_start_sel", {29'd0, sel0}, 32'd3);
        q0.push_back(8'h81); q1.push_back(8'h81);
        drive(1'b1, 1'b1, 1'b1);
        chk("start_sel", {29'd0, sel0}, 32'd1);
        for (int i = 1; i < 8; i++) drive(1'b1, (i == 7), 1'b0);
        chk("start_valid", {30'd0, valid0, valid1}, 32'h3);
        drive(1'b0, 1'b0, 1'b0);

        // Reset mid-word, inputs ignored while in reset, then 5A
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        check_zero("midreset");
        rst_n = 1'b1;
        q0.push_back(8'h5A); q1.push_back(8'h5A);
        send_byte(8'h5A);
        chk("rst_5a_valid", {30'd0, valid0, valid1}, 32'h3);
        drive(1'b0, 1'b0, 1'b0);

        // Gapped valid: counter holds across idle slots
        q0.push_back(8'h0F); q1.push_back(8'hF0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i < 4), 1'b0);
            if (i == 7) chk("gap_valid", {30'd0, valid0, valid1}, 32'h3);
            drive(1'b0, 1'b1, 1'b0);
            if (i < 7) chk("gap_sel_hold", {29'd0, sel0}, i + 1);
        end
        chk("gap_valid_fall", {30'd0, valid0, valid1}, 32'h0);
        chk("gap_ovr_none", ovr_cnt0 + ovr_cnt1, 32'd2);

        drive(1'b0, 1'b0, 1'b0);
        chk("queue0_drained", q0.size(), 32'd0);
        chk("queue1_drained", q1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
